// File: rtl/id_ctrl_issue.sv
// id_ctrl_issue: decodes the ID instruction into the registered 18-bit EX control bundle, with flush/load-use bubbles.
// Define ID_HAZARD_DETECT_EN to enable load-use stalling; otherwise the fetch enables stay at 1.
module id_ctrl_issue #(
    parameter logic [17:0] NOP_BUNDLE = 18'h00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        flush,
    output logic [17:0] control_signals,
    output logic [4:0]  dest_reg,
    output logic        ex_valid,
    output logic        pc_le,
    output logic        if_id_le,
    output logic [15:0] bubble_count
);
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND = 4'h2, OR = 4'h3, XOR = 4'h4, NOR = 4'h5,
                           SLL = 4'h6, SRL = 4'h7, SRA = 4'h8, SLT = 4'h9, SLTU = 4'hA, PASS = 4'hB;
    localparam logic [10:0] BR = 11'h400, LD = 11'h200, RF = 11'h100, TA = 11'h080, ME = 11'h040,
                            MW = 11'h020, SZW = 11'h010, SZH = 11'h008, MS = 11'h004, LK = 11'h002, JP = 11'h001;

    logic [17:0] ctrl_q, ctrl_d, dec;
    logic [4:0]  dest_q, dest_d, dst;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hazard, stall, bubble, rt_src;

    wire [5:0] op    = instr[31:26];
    wire [5:0] funct = instr[5:0];
    wire [4:0] rs    = instr[25:21];
    wire [4:0] rt    = instr[20:16];
    wire [4:0] rd    = instr[15:11];

    function automatic logic [17:0] b(input logic [2:0] s, input logic [3:0] a, input logic [10:0] f);
        return {s, a, f};
    endfunction

    always_comb begin
        dec = NOP_BUNDLE;
        case (op)
            6'h00: case (funct)
                6'h20, 6'h21: dec = b(3'd0, ADD, RF);
                6'h22, 6'h23: dec = b(3'd0, SUB, RF);
                6'h24: dec = b(3'd0, AND, RF);
                6'h25: dec = b(3'd0, OR, RF);
                6'h26: dec = b(3'd0, XOR, RF);
                6'h27: dec = b(3'd0, NOR, RF);
                6'h2A: dec = b(3'd0, SLT, RF);
                6'h2B: dec = b(3'd0, SLTU, RF);
                6'h00: dec = b(3'd3, SLL, RF);
                6'h02: dec = b(3'd3, SRL, RF);
                6'h03: dec = b(3'd3, SRA, RF);
                6'h08: dec = b(3'd0, ADD, TA | JP);
                6'h09: dec = b(3'd5, PASS, RF | TA | LK | JP);
                default: dec = NOP_BUNDLE;
            endcase
            6'h08, 6'h09: dec = b(3'd1, ADD, RF);
            6'h0A: dec = b(3'd1, SLT, RF);
            6'h0B: dec = b(3'd1, SLTU, RF);
            6'h0C: dec = b(3'd2, AND, RF);
            6'h0D: dec = b(3'd2, OR, RF);
            6'h0E: dec = b(3'd2, XOR, RF);
            6'h0F: dec = b(3'd4, PASS, RF);
            6'h23: dec = b(3'd1, ADD, LD | RF | ME | SZW);
            6'h21: dec = b(3'd1, ADD, LD | RF | ME | SZH | MS);
            6'h25: dec = b(3'd1, ADD, LD | RF | ME | SZH);
            6'h20: dec = b(3'd1, ADD, LD | RF | ME | MS);
            6'h24: dec = b(3'd1, ADD, LD | RF | ME);
            6'h2B: dec = b(3'd1, ADD, ME | MW | SZW);
            6'h29: dec = b(3'd1, ADD, ME | MW | SZH);
            6'h28: dec = b(3'd1, ADD, ME | MW);
            6'h04, 6'h05: dec = b(3'd0, SUB, BR | TA);
            6'h02: dec = b(3'd0, ADD, TA | JP);
            6'h03: dec = b(3'd5, PASS, RF | TA | LK | JP);
            default: dec = NOP_BUNDLE;
        endcase
        // The all-zero word would otherwise decode as sll $0,$0,0
        if (instr == 32'h0) dec = NOP_BUNDLE;
    end

    assign dst    = !dec[8] ? 5'd0 : (op == 6'h00) ? rd : (op == 6'h03) ? 5'd31 : rt;
    assign rt_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
                    (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);

`ifdef ID_HAZARD_DETECT_EN
    assign hazard   = instr_valid & ctrl_q[9] & valid_q & (dest_q != 5'd0) &
                      ((dest_q == rs) | (rt_src & (dest_q == rt)));
    assign stall    = hazard & ~flush;
    assign pc_le    = ~stall;
    assign if_id_le = ~stall;
`else
    assign hazard   = 1'b0;
    assign stall    = 1'b0;
    assign pc_le    = 1'b1;
    assign if_id_le = 1'b1;
`endif

    assign bubble  = flush | stall | ~instr_valid;
    assign ctrl_d  = bubble ? NOP_BUNDLE : dec;
    assign dest_d  = bubble ? 5'd0 : dst;
    assign valid_d = ~bubble;
    assign cnt_d   = ((flush | stall) && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            dest_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign control_signals = ctrl_q;
    assign dest_reg        = dest_q;
    assign ex_valid        = valid_q;
    assign bubble_count    = cnt_q;
endmodule
